mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter sharing one data-memory port between the four MIPS cores.
- Each core's MEM stage raises a request. The arbiter grants one core at a time and sequences the transfer with the shared memory's ready handshake.
- It returns read data with a one-cycle done pulse. It drives a per-core stall into that core's pipeline freeze logic (PC write, IF/ID write, control-mux bubble).
- Sits between the core cluster and the shared memory controller.

Parameters:
NUM_CORES, 4, number of requesters; power of two, at least 2
WIDTH, 32, data width
ADDR_W, 32, address width
TIMEOUT, 255, max cycles waiting for mem_ready before aborting; must be 1 or more

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
core_req  input  NUM_CORES  per-core request; held high until that core's core_done or core_err
core_we  input  NUM_CORES  per-core write enable (1 = store, 0 = load)
core_addr  input  NUM_CORES*ADDR_W  packed addresses; core i occupies bits [i*ADDR_W +: ADDR_W]
core_wdata  input  NUM_CORES*WIDTH  packed store data, same packing
core_stall  output  NUM_CORES  freeze core i's pipeline
core_done  output  NUM_CORES  one-cycle completion pulse
core_err  output  NUM_CORES  one-cycle timeout pulse
core_rdata  output  WIDTH  load data; valid in the cycle core_done is high
mem_req  output  1  request to shared memory
mem_we  output  1  write enable to memory
mem_addr  output  ADDR_W  memory address
mem_wdata  output  WIDTH  memory write data
mem_rdata  input  WIDTH  memory read data; valid with mem_ready
mem_ready  input  1  memory completes the request this cycle

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state IDLE, rr_ptr=0, gnt_idx=0, timeout counter=0. mem_req, mem_we, mem_addr, mem_wdata=0. core_done, core_err=0. core_rdata=0.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - If any core_req is high, select the first requesting core searching upward from rr_ptr, wrapping modulo NUM_CORES.
  - On the same edge, latch gnt_idx, we, addr and wdata into mem_* registers, set mem_req=1, clear the counter, and go to BUSY.
  - If no core_req is high, stay in IDLE.
- BUSY:
  - mem_req=1, and all mem_* fields stay stable; later changes to core inputs are ignored.
  - If mem_ready=1: capture mem_rdata into core_rdata (also captured on stores; the value is don't-care), clear mem_req, and go to DONE.
  - Else if counter==TIMEOUT-1: clear mem_req and go to ERR.
  - Else increment the counter.
- DONE: core_done[gnt_idx]=1 for exactly one cycle, rr_ptr <= (gnt_idx+1) mod NUM_CORES, then go to IDLE.
- ERR: core_err[gnt_idx]=1 for one cycle, rr_ptr advances as in DONE, then go to IDLE.
- Stall (combinational): core_stall[i] = core_req[i] & ~core_done[i] & ~core_err[i].
  - A requesting core stays stalled through arbitration and while waiting.
  - The stall releases in the same cycle as its done or error pulse.
- Latency:
  - A request seen in IDLE in cycle 0 drives mem_req in cycle 1.
  - If mem_ready=1 in cycle 1, core_done rises in cycle 2 and IDLE is re-entered in cycle 3.
  - Minimum 3 cycles per transaction; a new grant can be made in cycle 3.
- Fairness: after any completion, the completed core has lowest priority. Any continuously requesting core is granted within NUM_CORES transactions.
- Core drops core_req mid-transaction: the transaction still completes and the done or error pulse is still issued; only the stall reflects the current core_req.
- mem_ready while not in BUSY is ignored.
- Reset mid-BUSY: mem_req drops at the reset edge. No done or error pulse is issued. The memory controller must tolerate an abandoned request.
- Counter width: clog2(TIMEOUT+1) bits; the counter never wraps.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, DONE, ERR);
  - the localparam IDX_W = clog2(NUM_CORES);
  - a pure function rr_pick(req, ptr) returning the grant index plus a valid flag.
- One natural sub-module: rr_select, a combinational rotate-priority-encode over NUM_CORES. Everything else is top level.

Test Plan:
- Single load: core 2 requests, addr 0x100, we=0; mem_ready=1 the cycle after mem_req rises, mem_rdata 0xDEADBEEF. Expect:
  - core_done[2] in cycle 2 with core_rdata=0xDEADBEEF;
  - core_stall[2] high in cycles 0-1 and low in cycle 2.
- All-four contention: cores 0-3 request at once, memory ready in 1 cycle. Expect:
  - grants in order 0,1,2,3, three cycles apart;
  - each waiting core stalled until its done pulse.
- Round-robin fairness: core 0 requests continuously; core 3 raises a request while core 0 is being served. Expect the next grant to go to core 3, not core 0.
- Store with wait states: core 1 stores 0x12345678 to 0x40; mem_ready delayed 5 cycles. Expect mem_addr, mem_wdata and mem_we=1 stable for all 5 cycles, then a single core_done[1].
- Timeout: TIMEOUT=4, mem_ready never asserts. Expect:
  - mem_req high for exactly 4 cycles;
  - core_err pulse for the granted core, with no core_done;
  - the next requester is granted afterwards.
- Reset mid-BUSY: rst_n=0 for one cycle during a wait. Expect:
  - all outputs 0 on the next cycle, with no pulses;
  - FSM in IDLE, and a re-asserted request is granted starting from core 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the shared data-memory arbiter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mem_arb_pkg;

  // Widest requester vector rr_pick can handle; instantiations use NUM_CORES <= CORES_MAX.
  localparam int CORES_MAX = 16;
  localparam int IDX_W     = $clog2(CORES_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping modulo n (n = active requester count).
  // Scanning offsets from high to low lets the smallest offset win without a break.
  function automatic pick_t rr_pick(input logic [CORES_MAX-1:0] req,
                                    input logic [IDX_W-1:0]     ptr,
                                    input int                   n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = CORES_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (req[k[IDX_W-1:0]]) begin
          p.vld = 1'b1;
          p.idx = k[IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Rotating-priority encoder: picks the first requester at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
// Ports: req (per-core requests), ptr (starting index),
//        gnt_vld (any request present), gnt_idx (selected core).
module mem_arbiter_rr_select
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]         req,
  input  logic [$clog2(NUM_CORES)-1:0] ptr,
  output logic                         gnt_vld,
  output logic [$clog2(NUM_CORES)-1:0] gnt_idx
);

  localparam int GW = $clog2(NUM_CORES);

  logic [CORES_MAX-1:0] req_ext;
  pick_t                pick;

  assign req_ext = CORES_MAX'(req);
  assign pick    = rr_pick(req_ext, IDX_W'(ptr), NUM_CORES);
  assign gnt_vld = pick.vld;
  assign gnt_idx = GW'(pick.idx);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_CORES cores.
// Latency: grant->mem_req 1 cycle; done/err pulse 1 cycle after mem_ready/timeout; 3 cycles min per transfer.
// Backpressure: waiting cores are frozen via core_stall; memory waits handled by mem_ready with timeout abort.
// Ports: core_req/we/addr/wdata in from cores; core_stall/done/err/rdata back to cores;
//        mem_req/we/addr/wdata out to memory controller; mem_rdata/mem_ready back from it.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*WIDTH-1:0]  core_wdata,
  output logic [NUM_CORES-1:0]        core_stall,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_err,
  output logic [WIDTH-1:0]            core_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [WIDTH-1:0]            mem_wdata,
  input  logic [WIDTH-1:0]            mem_rdata,
  input  logic                        mem_ready
);

  localparam int GW    = $clog2(NUM_CORES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic              sel_vld;
  logic [GW-1:0]     sel_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_wdata;

  mem_arbiter_rr_select #(.NUM_CORES(NUM_CORES)) u_sel (
    .req     (core_req),
    .ptr     (rr_ptr_q),
    .gnt_vld (sel_vld),
    .gnt_idx (sel_idx)
  );

  // Steer the selected core's request fields toward the mem_* registers.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (sel_idx == GW'(i)) begin
        sel_we    = core_we[i];
        sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_idx_d   = sel_idx;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Store completions also capture mem_rdata; the value is simply unused by the core.
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE, ERR: begin
        // NUM_CORES is a power of two, so the natural GW-bit wrap is the modulo.
        rr_ptr_d = gnt_idx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // DONE/ERR last exactly one cycle, so decoding the state gives single-cycle pulses.
  always_comb begin
    core_done = '0;
    core_err  = '0;
    if (state_q == DONE) core_done[gnt_idx_q] = 1'b1;
    if (state_q == ERR)  core_err[gnt_idx_q]  = 1'b1;
  end

  // Stall follows the live request so a core that drops its request is released at once.
  assign core_stall = core_req & ~core_done & ~core_err;

  assign core_rdata = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   core_req;
  logic [3:0]   core_we;
  logic [127:0] core_addr;
  logic [127:0] core_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ready;

  logic [3:0]   core_stall, core_done, core_err;
  logic [31:0]  core_rdata, mem_addr, mem_wdata;
  logic         mem_req, mem_we;

  logic [3:0]   t_core_stall, t_core_done, t_core_err;
  logic [31:0]  t_core_rdata, t_mem_addr, t_mem_wdata;
  logic         t_mem_req, t_mem_we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.NUM_CORES(4), .WIDTH(32), .ADDR_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
    .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Short-timeout instance sharing the same stimulus.
  mem_arbiter #(.NUM_CORES(4), .WIDTH(32), .ADDR_W(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(t_core_stall),
    .core_done(t_core_done), .core_err(t_core_err), .core_rdata(t_core_rdata),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_core(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    core_we[i]              = we;
    core_addr[i*32 +: 32]   = addr;
    core_wdata[i*32 +: 32]  = wdata;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    core_req   = '0;
    core_we    = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    core_addr  = '0;
    core_wdata = '0;
    do_reset;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    tick;
    #1;
    checks++; if ({mem_req, mem_we, core_done, core_err, core_stall} !== 13'd0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {mem_req, mem_we, core_done, core_err, core_stall}); end
    checks++; if ({mem_addr, mem_wdata, core_rdata} !== 96'd0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, core_rdata}); end
    // mem_ready while idle must have no effect
    rst_n = 1'b1;
    tick;
    #1;
    checks++; if ({mem_req, core_done} !== 5'd0) begin errors++;
      $display("FAIL idle_ready_1: got %b expected 0", {mem_req, core_done}); end
    tick;
    #1;
    checks++; if ({mem_req, core_done, core_err} !== 9'd0) begin errors++;
      $display("FAIL idle_ready_2: got %b expected 0", {mem_req, core_done, core_err}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_single_load;
    do_reset;
    set_core(2, 1'b0, 32'h100, 32'h0);
    core_req = 4'b0100;
    #1;
    checks++; if ({core_stall[2], mem_req} !== 2'b10) begin errors++;
      $display("FAIL load_c0: got stall/req %b expected 10", {core_stall[2], mem_req}); end
    tick;
    #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin errors++;
      $display("FAIL load_c1_mem: got %b %b %h expected 1 0 100", mem_req, mem_we, mem_addr); end
    checks++; if ({core_stall[2], core_done[2]} !== 2'b10) begin errors++;
      $display("FAIL load_c1_stall: got %b expected 10", {core_stall[2], core_done[2]}); end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (core_done !== 4'b0100) begin errors++;
      $display("FAIL load_done: got %b expected 0100", core_done); end
    checks++; if (core_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL load_rdata: got %h expected deadbeef", core_rdata); end
    checks++; if ({core_stall[2], mem_req} !== 2'b00) begin errors++;
      $display("FAIL load_c2_stall: got %b expected 00", {core_stall[2], mem_req}); end
    core_req = 4'b0000;
    tick;
    #1;
    checks++; if (core_done !== 4'b0000) begin errors++;
      $display("FAIL load_done_once: got %b expected 0000", core_done); end
  endtask

  task automatic test_contention;
    int prev_cyc;
    int waitn;
    logic [3:0] req;
    logic [3:0] exp_done;
    do_reset;
    for (int i = 0; i < 4; i++) set_core(i, 1'b0, 32'h200 + 32'(i * 16), 32'h0);
    req      = 4'hF;
    core_req = req;
    prev_cyc = -1;
    for (int g = 0; g < 4; g++) begin
      waitn = 0;
      do begin tick; #1; waitn++; end while (!mem_req && waitn < 8);
      checks++; if (mem_req !== 1'b1) begin errors++;
        $display("FAIL cont_grant_wait: got mem_req %b expected 1 for core %0d", mem_req, g); end
      checks++; if (mem_addr !== 32'h200 + 32'(g * 16)) begin errors++;
        $display("FAIL cont_order: got addr %h expected %h", mem_addr, 32'h200 + 32'(g * 16)); end
      if (prev_cyc >= 0) begin
        checks++; if (cyc - prev_cyc !== 3) begin errors++;
          $display("FAIL cont_spacing: got %0d cycles expected 3", cyc - prev_cyc); end
      end
      prev_cyc = cyc;
      checks++; if (core_stall !== req) begin errors++;
        $display("FAIL cont_stall_wait: got %b expected %b", core_stall, req); end
      mem_ready = 1'b1;
      mem_rdata = 32'hA0 + 32'(g);
      tick;
      mem_ready = 1'b0;
      #1;
      exp_done = 4'(1 << g);
      checks++; if (core_done !== exp_done) begin errors++;
        $display("FAIL cont_done: got %b expected %b", core_done, exp_done); end
      checks++; if (core_stall !== (req & ~exp_done)) begin errors++;
        $display("FAIL cont_stall_done: got %b expected %b", core_stall, req & ~exp_done); end
      req[g]   = 1'b0;
      core_req = req;
    end
  endtask

  task automatic test_fairness;
    do_reset;
    set_core(0, 1'b0, 32'h1000, 32'h0);
    set_core(3, 1'b0, 32'h3000, 32'h0);
    core_req = 4'b0001;
    tick;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h1000}) begin errors++;
      $display("FAIL fair_first: got %b %h expected 1 1000", mem_req, mem_addr); end
    core_req  = 4'b1001;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if ({core_done, core_stall} !== 8'b0001_1000) begin errors++;
      $display("FAIL fair_done0: got done/stall %b expected 00011000", {core_done, core_stall}); end
    tick;
    tick;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin errors++;
      $display("FAIL fair_next3: got %b %h expected 1 3000", mem_req, mem_addr); end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (core_done !== 4'b1000) begin errors++;
      $display("FAIL fair_done3: got %b expected 1000", core_done); end
    core_req = 4'b0001;
    tick;
    tick;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h1000}) begin errors++;
      $display("FAIL fair_back0: got %b %h expected 1 1000", mem_req, mem_addr); end
  endtask

  task automatic test_store_wait;
    do_reset;
    set_core(1, 1'b1, 32'h40, 32'h12345678);
    core_req = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      tick;
      #1;
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'h12345678}) begin errors++;
        $display("FAIL store_stable_%0d: got %b %b %h %h expected 1 1 40 12345678", k, mem_req, mem_we, mem_addr, mem_wdata); end
      checks++; if (core_done !== 4'b0000) begin errors++;
        $display("FAIL store_early_done_%0d: got %b expected 0000", k, core_done); end
      // later core-side changes must not leak into the held transfer
      if (k == 2) set_core(1, 1'b0, 32'h44, 32'hFFFF0000);
      if (k == 5) mem_ready = 1'b1;
    end
    tick;
    mem_ready = 1'b0;
    #1;
    checks++; if (core_done !== 4'b0010) begin errors++;
      $display("FAIL store_done: got %b expected 0010", core_done); end
    core_req = 4'b0000;
    tick;
    #1;
    checks++; if (core_done !== 4'b0000) begin errors++;
      $display("FAIL store_single: got %b expected 0000", core_done); end
  endtask

  task automatic test_timeout;
    do_reset;
    set_core(0, 1'b0, 32'hA00, 32'h0);
    set_core(2, 1'b0, 32'hA20, 32'h0);
    core_req = 4'b0101;
    for (int k = 1; k <= 5; k++) begin
      tick;
      #1;
      checks++; if (t_mem_req !== (k <= 4)) begin errors++;
        $display("FAIL to_req_%0d: got %b expected %b", k, t_mem_req, k <= 4); end
      checks++; if (t_core_done !== 4'b0000) begin errors++;
        $display("FAIL to_no_done_%0d: got %b expected 0000", k, t_core_done); end
    end
    checks++; if ({t_core_err, t_core_stall} !== 8'b0001_0100) begin errors++;
      $display("FAIL to_err: got err/stall %b expected 00010100", {t_core_err, t_core_stall}); end
    core_req = 4'b0100;
    tick;
    #1;
    checks++; if (t_core_err !== 4'b0000) begin errors++;
      $display("FAIL to_err_once: got %b expected 0000", t_core_err); end
    tick;
    #1;
    checks++; if ({t_mem_req, t_mem_addr} !== {1'b1, 32'hA20}) begin errors++;
      $display("FAIL to_next: got %b %h expected 1 a20", t_mem_req, t_mem_addr); end
  endtask

  task automatic test_reset_mid_busy;
    do_reset;
    set_core(1, 1'b0, 32'h500, 32'h0);
    core_req = 4'b0010;
    tick;
    mem_ready = 1'b1;
    mem_rdata = 32'h55;
    tick;
    mem_ready = 1'b0;
    core_req  = 4'b0000;
    tick;
    set_core(3, 1'b1, 32'h700, 32'h77);
    core_req = 4'b1000;
    tick;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin errors++;
      $display("FAIL rst_busy_grant: got %b %h expected 1 700", mem_req, mem_addr); end
    tick;
    rst_n = 1'b0;
    tick;
    #1;
    checks++; if ({mem_req, mem_we, core_done, core_err} !== 10'd0) begin errors++;
      $display("FAIL rst_busy_ctrl: got %b expected 0", {mem_req, mem_we, core_done, core_err}); end
    checks++; if ({mem_addr, mem_wdata, core_rdata} !== 96'd0) begin errors++;
      $display("FAIL rst_busy_data: got %h expected 0", {mem_addr, mem_wdata, core_rdata}); end
    rst_n = 1'b1;
    set_core(1, 1'b0, 32'h510, 32'h0);
    core_req = 4'b1010;
    #1;
    checks++; if ({core_stall, core_done, core_err} !== 12'b1010_0000_0000) begin errors++;
      $display("FAIL rst_busy_idle: got %b expected 101000000000", {core_stall, core_done, core_err}); end
    tick;
    #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h510}) begin errors++;
      $display("FAIL rst_busy_ptr0: got %b %h expected 1 510", mem_req, mem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    test_reset;
    test_single_load;
    test_contention;
    test_fairness;
    test_store_wait;
    test_timeout;
    test_reset_mid_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
